uart_autobaud_ctrl: RTL

- Auto-baud controller that configures the UART baud generator's 4-bit rate select.
- When armed, it measures the low pulse of a received sync character (0x55, 'U') on the rx line. It classifies the pulse width against the nine supported rates and drives the baud_rate_sel code.
- Sits between the rx pin and the baud generator; the UART RX/TX datapath is held off (busy) while it runs.

---
 rtl/uart_pkg.sv | 69 ++++++
 rtl/uart_rx_edge_det.sv | 43 ++++
 rtl/uart_autobaud_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART auto-baud controller.
//
// Holds the rate tables, the pulse-width classification constants, the
// auto-baud FSM state enum and the rate-select type. Also provides
// classify(), which maps a measured low-pulse width in clk cycles onto a
// rate code.
//
// Optional build macro: UART_AUTOBAUD_VERIFY_EN adds the two states used
// for the second, confirming measurement.
package uart_pkg;

  // Rate select code: 0 = 600 baud ... 8 = 115200 baud.
  typedef logic [3:0] sel_t;

  localparam int NUM_RATES = 9;

  // Baud generator terminal counts for 16x oversampling at 100 MHz,
  // indexed by rate code.
  localparam int unsigned FINAL_VALUE [NUM_RATES] =
    '{10416, 5208, 2604, 1302, 651, 325, 162, 108, 54};

  // Nominal bit periods in clk cycles (16 x FINAL_VALUE).
  localparam int unsigned BIT_PERIOD [NUM_RATES] =
    '{166656, 83328, 41664, 20832, 10416, 5200, 2592, 1728, 864};

  // Boundary between code i and code i+1: midpoint of the two nominal
  // bit periods. A width >= THRESHOLD[i] selects the slower code i.
  localparam int unsigned THRESHOLD [NUM_RATES-1] =
    '{124992, 62496, 31248, 15624, 7808, 3896, 2160, 1296};

  // Shorter than half the fastest bit is a glitch; two slowest bits or
  // more cannot be a valid start bit.
  localparam int unsigned GLITCH_MIN = 432;
  localparam int unsigned PULSE_MAX  = 333312;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_WAIT_FALL,
    ST_MEASURE,
    ST_DONE
`ifdef UART_AUTOBAUD_VERIFY_EN
    ,
    ST_WAIT_FALL2,
    ST_MEASURE2
`endif
  } ab_state_t;

  typedef struct packed {
    logic ok;   // width is inside the legal window
    sel_t sel;  // rate code, meaningful only when ok
  } class_t;

  // Width is zero-extended from the counter, so all comparisons are unsigned.
  function automatic class_t classify(input logic [31:0] width);
    class_t r;
    r.ok  = (width >= GLITCH_MIN) && (width < PULSE_MAX);
    r.sel = sel_t'(NUM_RATES - 1);
    // Walk from the fastest boundary to the slowest so the slowest
    // matching code is the one left in r.sel.
    for (int i = NUM_RATES - 2; i >= 0; i--) begin
      if (width >= THRESHOLD[i]) begin
        r.sel = sel_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_edge_det.sv
// Synchronizer and edge detector for the raw rx pin.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   rx       in   raw serial input, asynchronous to clk, idles high
//   rx_sync  out  rx after a 2-FF synchronizer
//   fall     out  high for one cycle after rx_sync goes 1 -> 0
//   rise     out  high for one cycle after rx_sync goes 0 -> 1
//
// Both edges see the same pipeline delay, so the distance between a fall
// and the following rise equals the low time on the pin in clk cycles.
module uart_rx_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_sync,
  output logic fall,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_sync = sync_q;
  assign fall    = prev_q & ~sync_q;
  assign rise    = ~prev_q & sync_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures the start-bit low pulse of a 0x55 sync
// character and drives the baud generator's rate select.
//
// Parameters:
//   CNT_BITS        width of the saturating pulse-width counter
//   TIMEOUT_CYCLES  max cycles from an accepted start to a falling edge
//   DEFAULT_SEL     rate code held out of reset and kept on error
//
// Ports:
//   clk            in   system clock (100 MHz)
//   reset_n        in   asynchronous active-low reset
//   rx             in   raw serial input, idles high
//   start          in   one-cycle arm pulse, ignored while busy
//   baud_rate_sel  out  rate code to the baud generator
//   busy           out  measurement in progress
//   done           out  one-cycle pulse, new baud_rate_sel valid
//   error          out  one-cycle pulse, timeout / glitch / too long / mismatch
//   locked         out  set with done, cleared on start or error
//
// Build macro UART_AUTOBAUD_VERIFY_EN: when defined, a second low pulse
// (data bit 1 of 0x55) is measured and must classify to the same code
// before the result is applied.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int          CNT_BITS       = 19,
  parameter int          TIMEOUT_CYCLES = 50_000_000,
  parameter logic [3:0]  DEFAULT_SEL    = 4'd4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       start,
  output logic [3:0] baud_rate_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       locked
);

  localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

  logic rx_sync;
  logic fall;
  logic rise;

  uart_rx_edge_det u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_sync (rx_sync),
    .fall    (fall),
    .rise    (rise)
  );

  ab_state_t            state_q, state_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [TMO_BITS-1:0]  tmo_q, tmo_d;
  sel_t                 sel_q, sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 locked_q, locked_d;
`ifdef UART_AUTOBAUD_VERIFY_EN
  sel_t                 sel1_q, sel1_d;
`endif

  logic [CNT_BITS-1:0]  count_inc;
  logic                 tmo_hit;
  class_t               cls;

  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;
  // tmo_q counts edges since the accept edge minus one, so this fires on
  // the TIMEOUT_CYCLES-th edge after start was accepted.
  assign tmo_hit   = (tmo_q == TMO_BITS'(TIMEOUT_CYCLES - 1));
  assign cls       = classify(32'(count_q));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tmo_d    = tmo_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
    sel1_d   = sel1_q;
`endif

    case (state_q)
      // DONE is the cycle the done pulse is visible; busy is already low
      // there, so a start is accepted just as in IDLE.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_WAIT_IDLE;
          busy_d   = 1'b1;
          locked_d = 1'b0;
          tmo_d    = '0;
        end
      end

      // Do not measure a low that was already in progress at arm time.
      ST_WAIT_IDLE: begin
        if (tmo_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (rx_sync) begin
            state_d = ST_WAIT_FALL;
          end
        end
      end

      // The fall is checked first so an edge on the expiry cycle wins.
      ST_WAIT_FALL: begin
        if (fall) begin
          state_d = ST_MEASURE;
          count_d = CNT_BITS'(1);
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_MEASURE: begin
        if (rise) begin
          if (!cls.ok) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
`ifdef UART_AUTOBAUD_VERIFY_EN
            sel1_d  = cls.sel;
            state_d = ST_WAIT_FALL2;
            tmo_d   = '0;
`else
            state_d  = ST_DONE;
            sel_d    = cls.sel;
            done_d   = 1'b1;
            locked_d = 1'b1;
            busy_d   = 1'b0;
`endif
          end
        end else begin
          count_d = count_inc;
        end
      end

`ifdef UART_AUTOBAUD_VERIFY_EN
      ST_WAIT_FALL2: begin
        if (fall) begin
          state_d = ST_MEASURE2;
          count_d = CNT_BITS'(1);
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_MEASURE2: begin
        if (rise) begin
          if (!cls.ok || (cls.sel != sel1_q)) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = ST_DONE;
            sel_d    = cls.sel;
            done_d   = 1'b1;
            locked_d = 1'b1;
            busy_d   = 1'b0;
          end
        end else begin
          count_d = count_inc;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      tmo_q    <= '0;
      sel_q    <= DEFAULT_SEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
`ifdef UART_AUTOBAUD_VERIFY_EN
      sel1_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      locked_q <= locked_d;
`ifdef UART_AUTOBAUD_VERIFY_EN
      sel1_q   <= sel1_d;
`endif
    end
  end

  assign baud_rate_sel = sel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign locked        = locked_q;

endmodule
